regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 87 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bus: requester handshakes, issue-stage reservations,
// scoreboard view and the registered register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_W    = $clog2(NUM_REGS)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*REG_W-1:0]  req_sel;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      reserve_valid;
  logic [REG_W-1:0]          reserve_sel;
  logic                      reserve_ready;
  logic [NUM_REGS-1:0]       busy;
  logic [REG_W-1:0]          rWrite_sel;
  logic                      write_reg_enable;
  logic [DATA_W-1:0]         write_data;

  modport master (
    output req_valid, req_sel, req_data, reserve_valid, reserve_sel,
    input  req_ready, reserve_ready, busy, rWrite_sel, write_reg_enable, write_data
  );

  modport slave (
    input  req_valid, req_sel, req_data, reserve_valid, reserve_sel,
    output req_ready, reserve_ready, busy, rWrite_sel, write_reg_enable, write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter in front of a register file, with a
// per-register busy scoreboard set by issue-stage reservations.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_W    = $clog2(NUM_REGS)
) (
  input logic                 clock,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [REG_W-1:0]    rwrite_sel_q, rwrite_sel_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [NUM_REQ-1:0]  grant;
  logic                xfer;
  logic [REG_W-1:0]    win_sel;
  logic [DATA_W-1:0]   win_data;
  logic [PTR_W-1:0]    win_next;
  logic                res_ok;
  int unsigned         idx;

  // Grant depends only on req_valid and ptr; sel/data are muxed afterwards.
  always_comb begin
    grant    = '0;
    xfer     = 1'b0;
    win_sel  = '0;
    win_data = '0;
    win_next = '0;
    idx      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr_q) + off) % NUM_REQ;
      if (!xfer && bus.req_valid[idx]) begin
        xfer       = 1'b1;
        grant[idx] = 1'b1;
        win_sel    = bus.req_sel[idx*REG_W +: REG_W];
        win_data   = bus.req_data[idx*DATA_W +: DATA_W];
        win_next   = PTR_W'((idx + 1) % NUM_REQ);
      end
    end
  end

  assign res_ok = bus.reserve_valid &&
                  ((bus.reserve_sel == '0) || !busy_q[bus.reserve_sel]);

  always_comb begin
    ptr_d  = xfer ? win_next : ptr_q;
    busy_d = busy_q;
    // Clear before set so a same-edge reservation of the same register wins.
    if (xfer)   busy_d[win_sel]         = 1'b0;
    if (res_ok) busy_d[bus.reserve_sel] = 1'b1;
    busy_d[0] = 1'b0;

    wen_d        = xfer && (win_sel != '0);
    rwrite_sel_d = wen_d ? win_sel  : rwrite_sel_q;
    wdata_d      = wen_d ? win_data : wdata_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q        <= '0;
      busy_q       <= '0;
      rwrite_sel_q <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
    end else begin
      ptr_q        <= ptr_d;
      busy_q       <= busy_d;
      rwrite_sel_q <= rwrite_sel_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.req_ready        = grant;
  assign bus.reserve_ready    = res_ok;
  assign bus.busy             = busy_q;
  assign bus.rWrite_sel       = rwrite_sel_q;
  assign bus.write_reg_enable = wen_q;
  assign bus.write_data       = wdata_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: driver predicts each edge's outcome from a behavioural
// model and queues it; a monitor pops and compares after every rising edge.
module tb_regfile_wb_arbiter;
  localparam int NR = 3;
  localparam int DW = 32;
  localparam int NG = 32;
  localparam int RW = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regfile_wb_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .NUM_REGS(NG), .REG_W(RW)) bus ();
  regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .NUM_REGS(NG), .REG_W(RW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          wen;
    logic [RW-1:0] sel;
    logic [DW-1:0] data;
    logic [NG-1:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  logic done = 1'b0;

  // Reference model state
  logic [NG-1:0] busy_m;
  int            ptr_m;
  logic [RW-1:0] last_sel;
  logic [DW-1:0] last_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy_m = '0; ptr_m = 0; last_sel = '0; last_data = '0;
  endtask

  // One cycle: drive at negedge, check combinational readies, predict the edge.
  task automatic step(input logic [NR-1:0] v, input logic [NR*RW-1:0] s,
                      input logic [NR*DW-1:0] d, input logic rv,
                      input logic [RW-1:0] rs, output int win);
    logic [NR-1:0] eg;
    logic          err;
    logic [RW-1:0] ws;
    exp_t          e;
    @(negedge clock);
    bus.req_valid = v; bus.req_sel = s; bus.req_data = d;
    bus.reserve_valid = rv; bus.reserve_sel = rs;
    #1;
    win = -1;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (ptr_m + k) % NR;
      if (win < 0 && v[i]) win = i;
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(eg));
    err = rv && (rs == 0 || !busy_m[rs]);
    check("reserve_ready", 64'(bus.reserve_ready), 64'(err));
    e.wen = 1'b0;
    if (win >= 0) begin
      ws = s[win*RW +: RW];
      if (ws != 0) begin
        e.wen = 1'b1; last_sel = ws; last_data = d[win*DW +: DW];
      end
      busy_m[ws] = 1'b0;
      ptr_m = (win + 1) % NR;
    end
    if (err && rs != 0) busy_m[rs] = 1'b1;
    e.sel = last_sel; e.data = last_data; e.busy = busy_m;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (!reset && !done) begin
        if (exp_q.size() == 0) begin
          if (bus.write_reg_enable) check("unexpected_write", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("write_reg_enable", 64'(bus.write_reg_enable), 64'(e.wen));
          check("rWrite_sel", 64'(bus.rWrite_sel), 64'(e.sel));
          check("write_data", 64'(bus.write_data), 64'(e.data));
          check("busy", 64'(bus.busy), 64'(e.busy));
        end
      end
    end
  end

  initial begin : driver
    int w;
    logic [NR-1:0]    pv;
    logic [NR*RW-1:0] ps;
    logic [NR*DW-1:0] pd;
    bus.req_valid = '0; bus.req_sel = '0; bus.req_data = '0;
    bus.reserve_valid = 1'b0; bus.reserve_sel = '0;
    model_reset();
    #1;
    check("rst_wen", 64'(bus.write_reg_enable), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_sel", 64'(bus.rWrite_sel), 64'(0));
    check("rst_data", 64'(bus.write_data), 64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Three requesters valid for six cycles: grants rotate 0,1,2,0,1,2
    for (int n = 0; n < 6; n++)
      step(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 1'b0, '0, w);

    // Reserve r5, then requester 1 writes 0xAA to r5
    step('0, '0, '0, 1'b1, 5'd5, w);
    step(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'h0000_00AA, 32'h0}, 1'b0, '0, w);

    // Requester 2 writes r0: accepted, no strobe; reserving r0 is always ready
    step(3'b100, '0, {32'hFFFF_FFFF, 64'h0}, 1'b0, '0, w);
    step('0, '0, '0, 1'b1, 5'd0, w);

    // busy[7] set; same-edge reserve + clear of r7; retry next cycle
    step('0, '0, '0, 1'b1, 5'd7, w);
    step(3'b001, {10'd0, 5'd7}, {64'h0, 32'h77}, 1'b1, 5'd7, w);
    step('0, '0, '0, 1'b1, 5'd7, w);

    // Reserve r9 while a transfer clears the idle r9: set wins
    step(3'b001, {10'd0, 5'd9}, {64'h0, 32'h99}, 1'b1, 5'd9, w);

    // Randomised traffic; ungranted requesters hold sel/data stable
    pv = '0; ps = '0; pd = '0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i] = 1'b1;
          ps[i*RW +: RW] = RW'($urandom_range(0, 15));
          pd[i*DW +: DW] = $urandom;
        end
      end
      step(pv, ps, pd, 1'($urandom_range(0, 1)), RW'($urandom_range(0, 15)), w);
      if (w >= 0) pv[w] = 1'b0;
    end

    // Drain scoreboard, then build busy = 0x0000_F0F0 from empty
    for (int n = 0; n < NR; n++) step(3'b111, {5'd3, 5'd2, 5'd1}, '0, 1'b0, '0, w);
    for (int r = 1; r < 16; r++) step('0, '0, '0, 1'b1, RW'(r), w);
    for (int r = 1; r < 16; r++)
      if (((32'h0000_F0F0 >> r) & 1) == 0)
        step(3'b001, {10'd0, 5'(r)}, '0, 1'b0, '0, w);
    for (int n = 0; n < 3; n++)
      step(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, '0, w);

    // Asynchronous reset in the middle of a write cycle
    @(negedge clock);
    #1;
    check("pre_rst_busy", 64'(bus.busy), 64'h0000_F0F0);
    check("pre_rst_wen", 64'(bus.write_reg_enable), 64'(1));
    reset = 1'b1;
    #1;
    check("async_rst_wen", 64'(bus.write_reg_enable), 64'(0));
    check("async_rst_busy", 64'(bus.busy), 64'(0));
    bus.req_valid = '0; bus.reserve_valid = 1'b0;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    step(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, '0, w);
    check("post_rst_winner", 64'(w), 64'(0));
    step('0, '0, '0, 1'b0, '0, w);

    @(posedge clock);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
